// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter between NUM_REQ byte
// requesters, with a per-grant burst limit and a tx_busy start timeout.
module uart_tx_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int START_TO  = 64,
    localparam int IDW      = $clog2(NUM_REQ),
    localparam int BW       = $clog2(MAX_BURST + 1),
    localparam int TOW      = $clog2(START_TO)
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [IDW-1:0]            grant_id,
    output logic                      grant_valid,
    output logic                      err_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic [IDW-1:0]      grant_id_q, grant_id_d;
    logic                grant_valid_q, grant_valid_d;
    logic                err_q, err_d;
    logic [BW-1:0]       burst_q, burst_d;
    logic [TOW-1:0]      to_q, to_d;
    logic [IDW-1:0]      last_q, last_d;

    logic [IDW-1:0]      winner_s;
    logic [IDW-1:0]      load_id_s;
    logic [DATA_W-1:0]   load_data_s;
    logic [TOW-1:0]      to_inc_s;
    logic                enter_load_s;

    // First requester found scanning circularly from the slot after the last owner.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDW-1:0]     last);
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && r[IDW'(idx)]) begin
                pick  = IDW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign winner_s    = rr_pick(req, last_q);
    assign load_id_s   = (state_q == ST_IDLE) ? winner_s : grant_id_q;
    assign load_data_s = req_data[int'(load_id_s)*DATA_W +: DATA_W];
    assign to_inc_s    = to_q + {{(TOW-1){1'b0}}, 1'b1};

    // Next-state and next-output computation for the grant sequencer.
    always_comb begin
        state_d       = state_q;
        ack_d         = {NUM_REQ{1'b0}};
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        err_d         = 1'b0;
        burst_d       = burst_q;
        to_d          = to_q;
        last_d        = last_q;
        enter_load_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_id_d    = winner_s;
                    grant_valid_d = 1'b1;
                    burst_d       = {BW{1'b0}};
                    enter_load_s  = 1'b1;
                    state_d       = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                burst_d = burst_q + {{(BW-1){1'b0}}, 1'b1};
                to_d    = {TOW{1'b0}};
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    to_d = to_inc_s;
                    // The byte is dropped: the transmitter never acknowledged the start.
                    if (to_inc_s == TOW'(START_TO - 1)) begin
                        err_d         = 1'b1;
                        grant_valid_d = 1'b0;
                        last_d        = grant_id_q;
                        state_d       = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_BUSY;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (req[grant_id_q] && (burst_q < BW'(MAX_BURST))) begin
                    enter_load_s = 1'b1;
                    state_d      = ST_LOAD;
                end else begin
                    grant_valid_d = 1'b0;
                    last_d        = grant_id_q;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase

        // Start pulse, ack and byte capture are registered on the edge into LOAD.
        if (enter_load_s) begin
            tx_start_d = 1'b1;
            ack_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << load_id_s;
            tx_data_d  = load_data_s;
        end else begin
            tx_start_d = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ack_q         <= {NUM_REQ{1'b0}};
            tx_data_q     <= {DATA_W{1'b0}};
            tx_start_q    <= 1'b0;
            grant_id_q    <= {IDW{1'b0}};
            grant_valid_q <= 1'b0;
            err_q         <= 1'b0;
            burst_q       <= {BW{1'b0}};
            to_q          <= {TOW{1'b0}};
            last_q        <= IDW'(NUM_REQ - 1);
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            err_q         <= err_d;
            burst_q       <= burst_d;
            to_q          <= to_d;
            last_q        <= last_d;
        end
    end

    assign ack         = ack_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin/burst reference model.
module tb_uart_tx_scheduler;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        busy;

    logic [3:0]  ack0, ack1;
    logic [7:0]  txd0, txd1;
    logic        st0, st1, gv0, gv1, er0, er1;
    logic [1:0]  gid0, gid1;

    logic [3:0]  m_ack;
    logic [7:0]  m_txd;
    logic        m_st, m_gv, m_er;
    logic [1:0]  m_gid;

    int          sel;
    int          n_vec;
    int          n_err;
    int          cnt[4];
    int          arrive[4];
    logic [7:0]  bytes[4][16];
    int          ord[64];
    int          ord_n;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4), .START_TO(TO)) dut0 (
        .clk_in(clk), .reset(rst), .req(req), .req_data(req_data), .ack(ack0),
        .tx_data(txd0), .tx_start(st0), .tx_busy(busy), .grant_id(gid0),
        .grant_valid(gv0), .err_timeout(er0));

    uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(1), .START_TO(TO)) dut1 (
        .clk_in(clk), .reset(rst), .req(req), .req_data(req_data), .ack(ack1),
        .tx_data(txd1), .tx_start(st1), .tx_busy(busy), .grant_id(gid1),
        .grant_valid(gv1), .err_timeout(er1));

    always_comb begin
        if (sel == 1) begin
            m_ack = ack1; m_txd = txd1; m_st = st1; m_gv = gv1; m_er = er1; m_gid = gid1;
        end else begin
            m_ack = ack0; m_txd = txd0; m_st = st0; m_gv = gv0; m_er = er0; m_gid = gid0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0; busy = 1'b0; req_data = 32'h0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Next requester after 'last' in circular order that holds a request.
    function automatic int rr_model(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return last;
    endfunction

    // Traffic engine: requesters hold queues cnt[i] long from cycle arrive[i];
    // transmitter goes busy 1..3 cycles after each start for 2..6 cycles.
    task automatic run_traffic(input int s);
        int idx[4];
        bit owned, exp_start, done;
        int owner, burst, last, hi_from, fend, mb, total, sent, exp_id, d, len, e;
        logic [3:0]  rin;
        logic [31:0] rdat;
        logic [7:0]  exp_byte;
        sel = s;
        mb  = (s == 1) ? 1 : 4;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 16; k++) bytes[i][k] = 8'($urandom);
        do_reset();
        total = 0;
        for (int i = 0; i < 4; i++) begin idx[i] = 0; total += cnt[i]; end
        owned = 0; owner = 0; burst = 0; last = 3; hi_from = -1; fend = -1;
        sent = 0; ord_n = 0; done = 0; e = 0;
        for (int i = 0; i < 4; i++) begin
            req[i] = (arrive[i] <= 0) && (idx[i] < cnt[i]);
            req_data[i*8 +: 8] = bytes[i][idx[i]];
        end
        busy = 1'b0;
        while (!done && e < 2000) begin
            rin = req; rdat = req_data;
            step();
            exp_start = 0; exp_id = 0;
            if (owned && e == fend) begin
                if (rin[owner] && burst < mb) begin
                    exp_start = 1; exp_id = owner; burst++;
                end else begin
                    owned = 0; last = owner;
                end
            end else if (!owned && rin != 4'b0) begin
                exp_id = rr_model(rin, last);
                exp_start = 1; owned = 1; owner = exp_id; burst = 1;
            end
            exp_byte = rdat[exp_id*8 +: 8];
            n_vec++;
            if (m_st !== exp_start || m_gv !== owned || m_er !== 1'b0) begin
                n_err++;
                $display("FAIL traffic_ctrl cyc=%0d got st/gv/er=%b%b%b want %b%b0",
                         e, m_st, m_gv, m_er, exp_start, owned);
            end
            n_vec++;
            if (exp_start) begin
                if (m_ack !== (4'b0001 << exp_id) || m_gid !== 2'(exp_id) || m_txd !== exp_byte) begin
                    n_err++;
                    $display("FAIL traffic_grant cyc=%0d got ack=%b id=%0d data=%h want id=%0d data=%h",
                             e, m_ack, m_gid, m_txd, exp_id, exp_byte);
                end
                ord[ord_n] = exp_id;
                if (ord_n < 63) ord_n++;
                idx[exp_id]++; sent++;
                d = $urandom_range(1, 3); len = $urandom_range(2, 6);
                hi_from = e + d; fend = e + d + len;
            end else begin
                if (m_ack !== 4'b0) begin
                    n_err++;
                    $display("FAIL traffic_ack cyc=%0d got ack=%b want 0000", e, m_ack);
                end
            end
            if (!owned && sent == total && e >= 2) done = 1;
            e++;
            for (int i = 0; i < 4; i++) begin
                req[i] = (arrive[i] <= e) && (idx[i] < cnt[i]);
                req_data[i*8 +: 8] = bytes[i][idx[i]];
            end
            busy = (e >= hi_from) && (e < fend);
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL traffic_bound got sent=%0d want %0d within 2000 cycles", sent, total);
        end
        req = 4'b0; busy = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0;
        rst = 1'b1; req = 4'b1111; busy = 1'b1; req_data = 32'hFFFF_FFFF;
        step();
        step();
        n_vec++;
        if ({m_ack, m_txd, m_st, m_gid, m_gv, m_er} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_dut0 got %h want 0", {m_ack, m_txd, m_st, m_gid, m_gv, m_er});
        end
        n_vec++;
        if ({ack1, txd1, st1, gid1, gv1, er1} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_dut1 got %h want 0", {ack1, txd1, st1, gid1, gv1, er1});
        end
        rst = 1'b0; req = 4'b0; busy = 1'b0;
    endtask

    task automatic test_single();
        sel = 0;
        do_reset();
        req = 4'b0001; req_data = 32'h0000_00A5;
        step();
        n_vec++;
        if ({m_st, m_ack, m_txd, m_gv, m_gid} !== {1'b1, 4'b0001, 8'hA5, 1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL single_start got st=%b ack=%b data=%h gv=%b id=%0d want 1 0001 a5 1 0",
                     m_st, m_ack, m_txd, m_gv, m_gid);
        end
        req = 4'b0; busy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            n_vec++;
            if (m_st !== 1'b0 || m_ack !== 4'b0 || m_gv !== 1'b1 || m_txd !== 8'hA5) begin
                n_err++;
                $display("FAIL single_frame k=%0d got st=%b ack=%b gv=%b data=%h want 0 0000 1 a5",
                         k, m_st, m_ack, m_gv, m_txd);
            end
        end
        busy = 1'b0;
        step();
        n_vec++;
        if (m_gv !== 1'b0 || m_st !== 1'b0) begin
            n_err++;
            $display("FAIL single_release got gv=%b st=%b want 0 0", m_gv, m_st);
        end
    endtask

    task automatic test_round_robin();
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        cnt = '{2, 1, 1, 1}; arrive = '{0, 0, 0, 0};
        run_traffic(1);
        n_vec++;
        if (ord_n !== 5) begin
            n_err++;
            $display("FAIL rr_count got %0d want 5", ord_n);
        end
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (ord[k] !== exp_ord[k]) begin
                n_err++;
                $display("FAIL rr_order k=%0d got %0d want %0d", k, ord[k], exp_ord[k]);
            end
        end
    endtask

    task automatic test_burst();
        int exp_ord[6] = '{0, 0, 0, 0, 2, 2};
        cnt = '{0, 0, 6, 0}; arrive = '{0, 0, 0, 0};
        run_traffic(0);
        n_vec++;
        if (ord_n !== 6) begin
            n_err++;
            $display("FAIL burst_count got %0d want 6", ord_n);
        end
        cnt = '{6, 0, 2, 0};
        run_traffic(0);
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if (ord[k] !== exp_ord[k]) begin
                n_err++;
                $display("FAIL burst_order k=%0d got %0d want %0d", k, ord[k], exp_ord[k]);
            end
        end
    endtask

    task automatic test_timeout();
        sel = 0;
        do_reset();
        req = 4'b0011; req_data = 32'h0000_2211;
        step();
        n_vec++;
        if (m_st !== 1'b1 || m_gid !== 2'd0 || m_txd !== 8'h11) begin
            n_err++;
            $display("FAIL to_start got st=%b id=%0d data=%h want 1 0 11", m_st, m_gid, m_txd);
        end
        req_data = 32'h0000_2212;
        for (int k = 1; k < TO; k++) begin
            step();
            n_vec++;
            if (m_er !== 1'b0 || m_gv !== 1'b1 || m_st !== 1'b0) begin
                n_err++;
                $display("FAIL to_wait k=%0d got er=%b gv=%b st=%b want 0 1 0", k, m_er, m_gv, m_st);
            end
        end
        step();
        n_vec++;
        if (m_er !== 1'b1 || m_gv !== 1'b0) begin
            n_err++;
            $display("FAIL to_pulse got er=%b gv=%b want 1 0", m_er, m_gv);
        end
        step();
        n_vec++;
        if (m_er !== 1'b0 || m_st !== 1'b1 || m_gid !== 2'd1 || m_ack !== 4'b0010 || m_txd !== 8'h22) begin
            n_err++;
            $display("FAIL to_next got er=%b st=%b id=%0d ack=%b data=%h want 0 1 1 0010 22",
                     m_er, m_st, m_gid, m_ack, m_txd);
        end
    endtask

    task automatic test_reset_mid();
        sel = 0;
        do_reset();
        req = 4'b1001; req_data = 32'h3300_0044;
        step();
        req = 4'b1000; busy = 1'b1;
        repeat (3) step();
        busy = 1'b0;
        step();
        n_vec++;
        if (m_gv !== 1'b0) begin
            n_err++;
            $display("FAIL rm_release got gv=%b want 0", m_gv);
        end
        step();
        n_vec++;
        if (m_st !== 1'b1 || m_gid !== 2'd3) begin
            n_err++;
            $display("FAIL rm_grant3 got st=%b id=%0d want 1 3", m_st, m_gid);
        end
        busy = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        step();
        n_vec++;
        if ({m_ack, m_txd, m_st, m_gid, m_gv, m_er} !== 17'h0) begin
            n_err++;
            $display("FAIL rm_reset got %h want 0", {m_ack, m_txd, m_st, m_gid, m_gv, m_er});
        end
        rst = 1'b0; busy = 1'b0; req = 4'b1001;
        step();
        n_vec++;
        if (m_st !== 1'b1 || m_gid !== 2'd0 || m_ack !== 4'b0001) begin
            n_err++;
            $display("FAIL rm_first got st=%b id=%0d ack=%b want 1 0 0001", m_st, m_gid, m_ack);
        end
    endtask

    task automatic test_req_drop();
        sel = 0;
        do_reset();
        req = 4'b0001; req_data = 32'h0000_005A;
        step();
        n_vec++;
        if (m_st !== 1'b1 || m_ack !== 4'b0001) begin
            n_err++;
            $display("FAIL drop_start got st=%b ack=%b want 1 0001", m_st, m_ack);
        end
        req_data = 32'h0000_005B; busy = 1'b1;
        repeat (3) step();
        req = 4'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if (m_ack !== 4'b0 || m_gv !== 1'b1) begin
                n_err++;
                $display("FAIL drop_hold k=%0d got ack=%b gv=%b want 0000 1", k, m_ack, m_gv);
            end
        end
        busy = 1'b0;
        step();
        n_vec++;
        if (m_gv !== 1'b0 || m_st !== 1'b0 || m_ack !== 4'b0) begin
            n_err++;
            $display("FAIL drop_release got gv=%b st=%b ack=%b want 0 0 0000", m_gv, m_st, m_ack);
        end
        step();
        n_vec++;
        if (m_st !== 1'b0 || m_ack !== 4'b0) begin
            n_err++;
            $display("FAIL drop_quiet got st=%b ack=%b want 0 0000", m_st, m_ack);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i]    = $urandom_range(0, 5);
                arrive[i] = $urandom_range(0, 30);
            end
            run_traffic(int'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; sel = 0;
        rst = 1'b1; req = 4'b0; req_data = 32'h0; busy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_timeout();
        test_reset_mid();
        test_req_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule
